// File: rtl/overlap_pkg.sv
// rtl/overlap_pkg.sv - shared types, default sizes and sum-reduction helpers for overlap_add_mc
package overlap_pkg;

  localparam int DEF_WIDTH    = 24;
  localparam int DEF_N        = 18;
  localparam int DEF_CHANNELS = 2;

  // Helpers operate on operands sign-extended to this width; callers keep the low WIDTH bits.
  localparam int MAX_WIDTH    = 64;

  typedef logic signed [DEF_WIDTH-1:0] sample_t;

  typedef enum logic {
    ADD,
    STORE
  } state_e;

  // Adds two sign-extended operands and clamps the result to a w-bit two's complement range.
  function automatic logic signed [MAX_WIDTH-1:0] sat_add(
    input logic signed [MAX_WIDTH-1:0] a,
    input logic signed [MAX_WIDTH-1:0] b,
    input int unsigned                 w
  );
    logic signed [MAX_WIDTH:0] sum;
    logic signed [MAX_WIDTH:0] one;
    logic signed [MAX_WIDTH:0] hi;
    logic signed [MAX_WIDTH:0] lo;
    one = {{MAX_WIDTH{1'b0}}, 1'b1};
    sum = {a[MAX_WIDTH-1], a} + {b[MAX_WIDTH-1], b};
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (sum > hi) begin
      return hi[MAX_WIDTH-1:0];
    end
    if (sum < lo) begin
      return lo[MAX_WIDTH-1:0];
    end
    return sum[MAX_WIDTH-1:0];
  endfunction

  // Plain two's complement add; truncating the result to WIDTH bits gives the wrapped sum.
  function automatic logic signed [MAX_WIDTH-1:0] wrap_add(
    input logic signed [MAX_WIDTH-1:0] a,
    input logic signed [MAX_WIDTH-1:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/overlap_hist_mem.sv
// rtl/overlap_hist_mem.sv - per-channel history store, one write port and one combinational read port
module overlap_hist_mem #(
  parameter int  WIDTH    = 24,
  parameter int  N        = 18,
  parameter int  CHANNELS = 2,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int OW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [CW-1:0]    wr_ch,
  input  logic [OW-1:0]    wr_off,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [CW-1:0]    rd_ch,
  input  logic [OW-1:0]    rd_off,
  output logic [WIDTH-1:0] rd_data
);

  localparam int            DEPTH = CHANNELS * N;
  localparam int            AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] N_A   = AW'(N);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  // Each channel owns a contiguous block of N entries.
  always_comb begin
    wr_addr = AW'(wr_ch) * N_A + AW'(wr_off);
    rd_addr = AW'(rd_ch) * N_A + AW'(rd_off);
    rd_data = mem_q[rd_addr];
  end

  // History contents are never reset; validity is tracked by the parent.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/overlap_add_mc.sv
// rtl/overlap_add_mc.sv - multi-channel IMDCT overlap-add stage; OVERLAP_ADD_SAT_EN selects saturating sums
module overlap_add_mc
  import overlap_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  N        = DEF_N,
  parameter int  CHANNELS = DEF_CHANNELS,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_sample,
  input  logic [CW-1:0]           in_channel,
  input  logic                    in_first,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_sample,
  output logic [CW-1:0]           out_channel,
  output logic                    out_last
);

  localparam int            IW           = $clog2(2 * N);
  localparam int            OW           = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW:0]   CH_LIM       = CHANNELS[CW:0];
  localparam logic [IW-1:0] IDX_HALF     = IW'(N);
  localparam logic [IW-1:0] IDX_ADD_LAST = IW'(N - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(2 * N - 1);

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cur_ch_q, cur_ch_d;
  logic                    cur_clr_q, cur_clr_d;
  logic [CHANNELS-1:0]     hist_valid_q, hist_valid_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] out_sample_q, out_sample_d;
  logic [CW-1:0]           out_channel_q, out_channel_d;
  logic                    out_last_q, out_last_d;

  logic [CW-1:0]               ch_in;
  logic [CW-1:0]               eff_ch;
  logic                        eff_clr;
  logic                        xfer;
  logic                        hist_use;
  logic [WIDTH-1:0]            hist_rd;
  logic signed [MAX_WIDTH-1:0] a_ext;
  logic signed [MAX_WIDTH-1:0] b_ext;
  logic signed [MAX_WIDTH-1:0] sum_full;
  logic                        unused_sum_hi;
  logic                        wr_en;
  logic [OW-1:0]               rd_off;
  logic [OW-1:0]               wr_off;

  overlap_hist_mem #(
    .WIDTH    (WIDTH),
    .N        (N),
    .CHANNELS (CHANNELS)
  ) u_hist_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_ch   (eff_ch),
    .wr_off  (wr_off),
    .wr_data (in_sample),
    .rd_ch   (eff_ch),
    .rd_off  (rd_off),
    .rd_data (hist_rd)
  );

  // Datapath: on sample 0 the latched channel/flag are not yet valid, so use the live inputs.
  always_comb begin
    ch_in         = ({1'b0, in_channel} < CH_LIM) ? in_channel : '0;
    eff_ch        = (idx_q == '0) ? ch_in : cur_ch_q;
    eff_clr       = (idx_q == '0) ? in_first : cur_clr_q;
    in_ready      = (state_q == ADD) ? (!out_valid_q || out_ready) : 1'b1;
    xfer          = in_valid && in_ready;
    hist_use      = !eff_clr && hist_valid_q[eff_ch];
    a_ext         = {{(MAX_WIDTH - WIDTH){in_sample[WIDTH-1]}}, in_sample};
    b_ext         = hist_use ? {{(MAX_WIDTH - WIDTH){hist_rd[WIDTH-1]}}, hist_rd} : '0;
`ifdef OVERLAP_ADD_SAT_EN
    sum_full      = sat_add(a_ext, b_ext, WIDTH);
`else
    sum_full      = wrap_add(a_ext, b_ext);
`endif
    unused_sum_hi = ^sum_full[MAX_WIDTH-1:WIDTH];
    rd_off        = idx_q[OW-1:0];
    wr_off        = OW'(idx_q - IDX_HALF);
    wr_en         = xfer && (state_q == STORE);
  end

  // Next state: ADD phase emits sums, STORE phase captures history and marks it valid at frame end.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cur_ch_d      = cur_ch_q;
    cur_clr_d     = cur_clr_q;
    hist_valid_d  = hist_valid_q;
    out_valid_d   = out_valid_q;
    out_sample_d  = out_sample_q;
    out_channel_d = out_channel_q;
    out_last_d    = out_last_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (xfer) begin
      if (idx_q == '0) begin
        cur_ch_d  = ch_in;
        cur_clr_d = in_first;
      end
      case (state_q)
        ADD: begin
          out_valid_d   = 1'b1;
          out_sample_d  = sum_full[WIDTH-1:0];
          out_channel_d = eff_ch;
          out_last_d    = (idx_q == IDX_ADD_LAST);
          idx_d         = idx_q + IW'(1);
          if (idx_q == IDX_ADD_LAST) begin
            state_d = STORE;
          end
        end
        STORE: begin
          if (idx_q == IDX_LAST) begin
            idx_d                  = '0;
            state_d                = ADD;
            hist_valid_d[cur_ch_q] = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: begin
          state_d = ADD;
        end
      endcase
    end
  end

  // State register; reset abandons any partial frame and invalidates all history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ADD;
      idx_q         <= '0;
      cur_ch_q      <= '0;
      cur_clr_q     <= 1'b0;
      hist_valid_q  <= '0;
      out_valid_q   <= 1'b0;
      out_sample_q  <= '0;
      out_channel_q <= '0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cur_ch_q      <= cur_ch_d;
      cur_clr_q     <= cur_clr_d;
      hist_valid_q  <= hist_valid_d;
      out_valid_q   <= out_valid_d;
      out_sample_q  <= out_sample_d;
      out_channel_q <= out_channel_d;
      out_last_q    <= out_last_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sample  = out_sample_q;
  assign out_channel = out_channel_q;
  assign out_last    = out_last_q;

endmodule

// File: tb/tb_overlap_add_mc.sv
// tb/tb_overlap_add_mc.sv - randomized self-checking bench for overlap_add_mc against a frame-level model
module tb_overlap_add_mc;

  localparam int WIDTH    = 24;
  localparam int N        = 18;
  localparam int CHANNELS = 2;
  localparam int CW       = 1;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_sample = '0;
  logic [CW-1:0]           in_channel = '0;
  logic                    in_first = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [WIDTH-1:0] out_sample;
  logic [CW-1:0]           out_channel;
  logic                    out_last;

  int tests = 0;
  int fails = 0;

  longint           frame_buf [2*N];
  longint           hist_m [CHANNELS][N];
  bit               hv_m [CHANNELS];
  logic [WIDTH-1:0] exp_s[$], obs_s[$];
  logic [CW-1:0]    exp_c[$], obs_c[$];
  bit               exp_l[$], obs_l[$];
  bit               bp_rand = 1'b0;

  always #5 clk = ~clk;

  overlap_add_mc #(.WIDTH(WIDTH), .N(N), .CHANNELS(CHANNELS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .in_channel(in_channel), .in_first(in_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .out_channel(out_channel), .out_last(out_last)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reduce an exact integer sum to the representable WIDTH-bit result.
  function automatic longint reduce(longint s);
    longint one, hi, lo, m;
    one = 1;
    hi  = (one <<< (WIDTH - 1)) - 1;
    lo  = -(one <<< (WIDTH - 1));
    m   = s;
`ifdef OVERLAP_ADD_SAT_EN
    if (s > hi) m = hi;
    if (s < lo) m = lo;
`else
    m = s & ((one <<< WIDTH) - 1);
    if (m > hi) m = m - (one <<< WIDTH);
`endif
    return m;
  endfunction

  task automatic model_frame(int ch, bit first);
    int            c;
    longint        h, r;
    logic [CW-1:0] cc;
    c  = (ch < CHANNELS) ? ch : 0;
    cc = c[CW-1:0];
    for (int i = 0; i < N; i++) begin
      h = (!first && hv_m[c]) ? hist_m[c][i] : 0;
      r = reduce(frame_buf[i] + h);
      exp_s.push_back(r[WIDTH-1:0]);
      exp_c.push_back(cc);
      exp_l.push_back(i == N - 1);
    end
    for (int i = 0; i < N; i++) hist_m[c][i] = frame_buf[N + i];
    hv_m[c] = 1'b1;
  endtask

  task automatic clear_q();
    exp_s.delete(); exp_c.delete(); exp_l.delete();
    obs_s.delete(); obs_c.delete(); obs_l.delete();
  endtask

  task automatic fill_const(longint v);
    for (int i = 0; i < 2*N; i++) frame_buf[i] = v;
  endtask

  task automatic fill_ramp(longint start);
    for (int i = 0; i < 2*N; i++) frame_buf[i] = start + i;
  endtask

  task automatic fill_rand();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < 2*N; i++) begin
      r = WIDTH'($urandom);
      frame_buf[i] = longint'(signed'(r));
    end
  endtask

  // One clock: observe at the falling edge, then move to just after the rising edge.
  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      obs_s.push_back(out_sample);
      obs_c.push_back(out_channel);
      obs_l.push_back(out_last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_range(int ch, bit first, int from, int upto);
    bit acc;
    int guard;
    for (int i = from; i < upto; i++) begin
      in_valid   = 1'b1;
      in_sample  = frame_buf[i][WIDTH-1:0];
      in_channel = (i == 0) ? ch[CW-1:0] : CW'($urandom);
      in_first   = (i == 0) ? first : 1'($urandom);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        out_ready = bp_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
        step(acc);
        guard++;
      end
      if (!acc) begin
        tests++; fails++;
        $display("FAIL handshake_timeout idx=%0d got no transfer, required one within 200 cycles", i);
      end
    end
  endtask

  task automatic flush();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step(acc);
  endtask

  task automatic run_frame(int ch, bit first);
    model_frame(ch, first);
    drive_range(ch, first, 0, 2*N);
    flush();
  endtask

  task automatic test_reset();
    bit acc;
    reset = 1'b0;
    #12;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0d required 0", out_valid); end
    tests++; if (out_sample !== '0) begin fails++; $display("FAIL reset_out_sample got %h required 0", out_sample); end
    tests++; if (out_channel !== '0) begin fails++; $display("FAIL reset_out_channel got %0d required 0", out_channel); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last got %0d required 0", out_last); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0d required 1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < CHANNELS; c++) hv_m[c] = 1'b0;
    step(acc);
  endtask

  task automatic test_overlap_frames();
    clear_q();
    bp_rand = 1'b0;
    fill_ramp(1);    run_frame(0, 1'b0);
    fill_const(100); run_frame(0, 1'b0);
    tests++; if (obs_s.size() != exp_s.size()) begin fails++; $display("FAIL overlap_count got %0d required %0d", obs_s.size(), exp_s.size()); end
    for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++) begin
      tests++;
      if (obs_s[i] !== exp_s[i] || obs_c[i] !== exp_c[i] || obs_l[i] !== exp_l[i]) begin
        fails++;
        $display("FAIL overlap[%0d] got s=%h c=%0d l=%0d required s=%h c=%0d l=%0d", i, obs_s[i], obs_c[i], obs_l[i], exp_s[i], exp_c[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_interleave();
    clear_q();
    fill_const(5); run_frame(0, 1'b0);
    fill_const(7); run_frame(1, 1'b0);
    fill_const(1); run_frame(0, 1'b0);
    fill_const(2); run_frame(1, 1'b0);
    tests++; if (obs_s.size() != exp_s.size()) begin fails++; $display("FAIL interleave_count got %0d required %0d", obs_s.size(), exp_s.size()); end
    for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++) begin
      tests++;
      if (obs_s[i] !== exp_s[i] || obs_c[i] !== exp_c[i] || obs_l[i] !== exp_l[i]) begin
        fails++;
        $display("FAIL interleave[%0d] got s=%h c=%0d l=%0d required s=%h c=%0d l=%0d", i, obs_s[i], obs_c[i], obs_l[i], exp_s[i], exp_c[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_first_flag();
    clear_q();
    fill_const(50); run_frame(1, 1'b0);
    fill_const(3);  run_frame(1, 1'b1);
    fill_const(4);  run_frame(1, 1'b0);
    tests++; if (obs_s.size() != exp_s.size()) begin fails++; $display("FAIL first_flag_count got %0d required %0d", obs_s.size(), exp_s.size()); end
    for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++) begin
      tests++;
      if (obs_s[i] !== exp_s[i] || obs_c[i] !== exp_c[i] || obs_l[i] !== exp_l[i]) begin
        fails++;
        $display("FAIL first_flag[%0d] got s=%h c=%0d l=%0d required s=%h c=%0d l=%0d", i, obs_s[i], obs_c[i], obs_l[i], exp_s[i], exp_c[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_overflow();
    clear_q();
    fill_const(64'sd8388607);  run_frame(0, 1'b1);
    fill_const(1);             run_frame(0, 1'b0);
    fill_const(-64'sd8388608); run_frame(1, 1'b1);
    fill_const(-1);            run_frame(1, 1'b0);
    tests++; if (obs_s.size() != exp_s.size()) begin fails++; $display("FAIL overflow_count got %0d required %0d", obs_s.size(), exp_s.size()); end
    for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++) begin
      tests++;
      if (obs_s[i] !== exp_s[i] || obs_c[i] !== exp_c[i] || obs_l[i] !== exp_l[i]) begin
        fails++;
        $display("FAIL overflow[%0d] got s=%h c=%0d l=%0d required s=%h c=%0d l=%0d", i, obs_s[i], obs_c[i], obs_l[i], exp_s[i], exp_c[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    bp_rand = 1'b0;
    fill_ramp(200);
    model_frame(1, 1'b0);
    drive_range(1, 1'b0, 0, 4);
    in_sample = frame_buf[4][WIDTH-1:0];
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sample !== exp_s[3] || out_channel !== exp_c[3] || out_last !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold got rdy=%0d v=%0d s=%h c=%0d l=%0d required rdy=0 v=1 s=%h c=%0d l=0", in_ready, out_valid, out_sample, out_channel, out_last, exp_s[3], exp_c[3]);
      end
      @(posedge clk); #1;
    end
    drive_range(1, 1'b0, 4, 2*N);
    flush();
    tests++; if (obs_s.size() != exp_s.size()) begin fails++; $display("FAIL backpressure_count got %0d required %0d", obs_s.size(), exp_s.size()); end
    for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++) begin
      tests++;
      if (obs_s[i] !== exp_s[i] || obs_c[i] !== exp_c[i] || obs_l[i] !== exp_l[i]) begin
        fails++;
        $display("FAIL backpressure[%0d] got s=%h c=%0d l=%0d required s=%h c=%0d l=%0d", i, obs_s[i], obs_c[i], obs_l[i], exp_s[i], exp_c[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit acc;
    clear_q();
    fill_ramp(300);
    drive_range(0, 1'b0, 0, 25);
    in_valid = 1'b0;
    reset = 1'b0;
    #2;
    tests++;
    if (out_valid !== 1'b0 || out_sample !== '0 || out_channel !== '0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midframe_reset got v=%0d s=%h c=%0d l=%0d rdy=%0d required v=0 s=0 c=0 l=0 rdy=1", out_valid, out_sample, out_channel, out_last, in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < CHANNELS; c++) hv_m[c] = 1'b0;
    step(acc);
    clear_q();
    fill_ramp(-10); run_frame(0, 1'b0);
    fill_ramp(40);  run_frame(1, 1'b0);
    tests++; if (obs_s.size() != exp_s.size()) begin fails++; $display("FAIL after_reset_count got %0d required %0d", obs_s.size(), exp_s.size()); end
    for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++) begin
      tests++;
      if (obs_s[i] !== exp_s[i] || obs_c[i] !== exp_c[i] || obs_l[i] !== exp_l[i]) begin
        fails++;
        $display("FAIL after_reset[%0d] got s=%h c=%0d l=%0d required s=%h c=%0d l=%0d", i, obs_s[i], obs_c[i], obs_l[i], exp_s[i], exp_c[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_random();
    clear_q();
    bp_rand = 1'b1;
    for (int f = 0; f < 14; f++) begin
      fill_rand();
      run_frame($urandom_range(0, CHANNELS - 1), ($urandom_range(0, 3) == 0));
    end
    bp_rand = 1'b0;
    tests++; if (obs_s.size() != exp_s.size()) begin fails++; $display("FAIL random_count got %0d required %0d", obs_s.size(), exp_s.size()); end
    for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++) begin
      tests++;
      if (obs_s[i] !== exp_s[i] || obs_c[i] !== exp_c[i] || obs_l[i] !== exp_l[i]) begin
        fails++;
        $display("FAIL random[%0d] got s=%h c=%0d l=%0d required s=%h c=%0d l=%0d", i, obs_s[i], obs_c[i], obs_l[i], exp_s[i], exp_c[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap_frames();
    test_interleave();
    test_first_flag();
    test_overflow();
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
